// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and shared types for
// the VGA sync generator. The generator copies these into its parameters, so
// a different raster only needs parameter overrides at instantiation.
package vga_timing_pkg;

  localparam int unsigned VGA_COORD_W = 10;

  localparam int unsigned VGA_CLK_DIV    = 4;
  localparam int unsigned VGA_PIPE_DELAY = 1;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // First and last counter values (inclusive) on which each sync is asserted.
  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // Level a sync pin takes while asserted; 0 means the classic active-low VGA.
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef logic [VGA_COORD_W-1:0] coord_t;

  // Inclusive window test shared by the hsync and vsync decoders.
  function automatic logic inWindow(input coord_t value, input coord_t lo, input coord_t hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register of WIDTH bits that advances on
// every clock. Used to line the sync/blank outputs up with the block-ROM read
// latency. A synchronous active-low reset loads RESET_VAL into every stage so
// no stale sync level survives a reset. DEPTH=0 degenerates to a plain wire.
module sync_delay_line #(
  parameter int unsigned      WIDTH     = 3,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_reset;
    assign unused_clk_reset = clk_i ^ reset_ni;
    assign data_o = data_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock, flushing the whole line on reset.
    always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VAL;
        end
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: raster timing generator. A clock divider produces the
// pixel tick, the horizontal/vertical counters step on tick edges, and the
// video_on/hsync/vsync/frame_start flags are registered from the counters'
// next values so they change on the same edge as curr_x/curr_y. A delayed
// copy of the sync and blank flags compensates for the frame-ROM latency.
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV    = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter logic        SYNC_POL   = VGA_SYNC_POL,
  parameter int unsigned PIPE_DELAY = VGA_PIPE_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] curr_x,
  output logic [9:0] curr_y,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       video_on_d
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters are 10 bits wide; a larger raster cannot be represented.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_sync_generator: H_TOTAL exceeds the 10-bit counter range");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_sync_generator: V_TOTAL exceeds the 10-bit counter range");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_sync_generator: CLK_DIV must be at least 1");
  end

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam coord_t X_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t X_ACTIVE     = coord_t'(H_ACTIVE);
  localparam coord_t Y_ACTIVE     = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  coord_t           x_q, x_d;
  coord_t           y_q, y_d;
  logic             video_on_q, video_on_d_int;
  logic             hsync_q, hsync_d_int;
  logic             vsync_q, vsync_d_int;
  logic             frame_start_q, frame_start_d_int;
  logic [2:0]       delay_out;

  // The last divider phase of each pixel is the tick cycle.
  assign pixel_tick = (div_q == DIV_LAST);

  // Divider phase advances every clock and wraps after the tick cycle.
  always_comb begin
    div_d = div_q + 1'b1;
    if (pixel_tick) begin
      div_d = '0;
    end
  end

  // Next raster position: x steps each tick, y steps only when x wraps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pixel_tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Flags decoded from the next position so they register alongside it.
  always_comb begin
    video_on_d_int    = (x_d < X_ACTIVE) && (y_d < Y_ACTIVE);
    hsync_d_int       = inWindow(x_d, H_SYNC_FIRST, H_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d_int       = inWindow(y_d, V_SYNC_FIRST, V_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    frame_start_d_int = pixel_tick && (x_d == '0) && (y_d == '0);
  end

  // Divider and counter state; reset parks the counters on the last pixel
  // so the first tick after release lands on (0,0).
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
      x_q   <= X_LAST;
      y_q   <= Y_LAST;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  // Registered sync, blank and frame-start flags, inactive during reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      video_on_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      video_on_q    <= video_on_d_int;
      hsync_q       <= hsync_d_int;
      vsync_q       <= vsync_d_int;
      frame_start_q <= frame_start_d_int;
    end
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_delay (
    .clk_i    (clk),
    .reset_ni (reset),
    .data_i   ({hsync_q, vsync_q, video_on_q}),
    .data_o   (delay_out)
  );

  assign curr_x      = x_q;
  assign curr_y      = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign {hsync_d, vsync_d, video_on_d} = delay_out;

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: three generator instances (default timing, and two
// tiny rasters with other divider/polarity/delay settings) share a clock and
// reset. A behavioural model derives every output from the number of clock
// edges since the last reset edge; literal expectations pin key points.
module tb_vga_sync_generator;

  typedef struct {
    int   div;
    int   ha, hfp, hsy, hbp;
    int   va, vfp, vsy, vbp;
    logic pol;
    int   dly;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       fs;
    logic       hs;
    logic       vs;
  } raster_t;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       hsd;
    logic       vsd;
    logic       vond;
  } obs_t;

  logic clk;
  logic reset;

  logic       dTick, dVon, dFs, dHs, dVs, dHsd, dVsd, dVond;
  logic [9:0] dX, dY;
  logic       aTick, aVon, aFs, aHs, aVs, aHsd, aVsd, aVond;
  logic [9:0] aX, aY;
  logic       bTick, bVon, bFs, bHs, bVs, bHsd, bVsd, bVond;
  logic [9:0] bX, bY;

  cfg_t cDef, cA, cB;
  int   checks = 0;
  int   errors = 0;
  int   kCnt = 0;
  bit   kValid = 1'b0;
  int   hsLowTicks = 0;
  int   hsWidthChecked = 0;
  bit   fsSeen = 1'b0;
  int   fsK = 0;
  int   periodCount = 0;

  vga_sync_generator uDef (
    .clk(clk), .reset(reset), .pixel_tick(dTick), .curr_x(dX), .curr_y(dY),
    .video_on(dVon), .frame_start(dFs), .hsync(dHs), .vsync(dVs),
    .hsync_d(dHsd), .vsync_d(dVsd), .video_on_d(dVond)
  );

  vga_sync_generator #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIPE_DELAY(3)
  ) uSmallA (
    .clk(clk), .reset(reset), .pixel_tick(aTick), .curr_x(aX), .curr_y(aY),
    .video_on(aVon), .frame_start(aFs), .hsync(aHs), .vsync(aVs),
    .hsync_d(aHsd), .vsync_d(aVsd), .video_on_d(aVond)
  );

  vga_sync_generator #(
    .CLK_DIV(2), .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) uSmallB (
    .clk(clk), .reset(reset), .pixel_tick(bTick), .curr_x(bX), .curr_y(bY),
    .video_on(bVon), .frame_start(bFs), .hsync(bHs), .vsync(bVs),
    .hsync_d(bHsd), .vsync_d(bVsd), .video_on_d(bVond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the most recent reset edge; reset held keeps it at zero.
  always @(posedge clk) begin
    if (!reset) begin
      kCnt   <= 0;
      kValid <= 1'b1;
    end else begin
      kCnt <= kCnt + 1;
    end
  end

  // Raster state visible after k edges: tick n (n>=1) closes at edge n*div
  // and shows pixel n-1 of the frame sequence; before any tick the outputs
  // hold their reset values.
  function automatic raster_t rasterAt(input cfg_t c, input int k);
    raster_t r;
    int ht, vt, ticks, p, xi, yi;
    ht    = c.ha + c.hfp + c.hsy + c.hbp;
    vt    = c.va + c.vfp + c.vsy + c.vbp;
    ticks = (k > 0) ? (k / c.div) : 0;
    if (ticks == 0) begin
      r.x   = 10'(ht - 1);
      r.y   = 10'(vt - 1);
      r.von = 1'b0;
      r.fs  = 1'b0;
      r.hs  = ~c.pol;
      r.vs  = ~c.pol;
    end else begin
      p     = (ticks - 1) % (ht * vt);
      xi    = p % ht;
      yi    = p / ht;
      r.x   = 10'(xi);
      r.y   = 10'(yi);
      r.von = (xi < c.ha) && (yi < c.va);
      r.fs  = (p == 0) && ((k % c.div) == 0);
      r.hs  = (xi >= c.ha + c.hfp && xi < c.ha + c.hfp + c.hsy) ? c.pol : ~c.pol;
      r.vs  = (yi >= c.va + c.vfp && yi < c.va + c.vfp + c.vsy) ? c.pol : ~c.pol;
    end
    return r;
  endfunction

  function automatic obs_t expectedObs(input cfg_t c, input int k);
    raster_t a, d;
    obs_t o;
    a = rasterAt(c, k);
    d = rasterAt(c, k - c.dly);
    o.tick = ((k % c.div) == (c.div - 1));
    o.x    = a.x;
    o.y    = a.y;
    o.von  = a.von;
    o.fs   = a.fs;
    o.hs   = a.hs;
    o.vs   = a.vs;
    o.hsd  = d.hs;
    o.vsd  = d.vs;
    o.vond = d.von;
    return o;
  endfunction

  task automatic compareCycle(input string name, input obs_t act, input obs_t exp, input int k);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s k=%0d got %h required %h (tick,x,y,von,fs,hs,vs,hs_d,vs_d,von_d)",
               name, k, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d required %0d at k=%0d", name, actual, expected, kCnt);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
  endtask

  task automatic pulseReset(input int holdEdges);
    @(posedge clk);
    #($urandom_range(1, 4));
    reset = 1'b0;
    repeat (holdEdges) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Every cycle: compare all instances against the model, plus literal
  // points and line/frame measurements.
  always @(negedge clk) begin
    if (kValid) begin
      compareCycle("def", {dTick, dX, dY, dVon, dFs, dHs, dVs, dHsd, dVsd, dVond},
                   expectedObs(cDef, kCnt), kCnt);
      compareCycle("smallA", {aTick, aX, aY, aVon, aFs, aHs, aVs, aHsd, aVsd, aVond},
                   expectedObs(cA, kCnt), kCnt);
      compareCycle("smallB", {bTick, bX, bY, bVon, bFs, bHs, bVs, bHsd, bVsd, bVond},
                   expectedObs(cB, kCnt), kCnt);

      case (kCnt)
        0: begin
          checkOutput("def_reset_x", dX, 799);
          checkOutput("def_reset_y", dY, 524);
          checkOutput("def_reset_flags", {dTick, dVon, dFs, dHs, dVs, dHsd, dVsd, dVond}, 8'b00011110);
        end
        3:    checkOutput("def_first_tick", {dTick, dX}, {1'b1, 10'd799});
        4: begin
          checkOutput("def_first_pixel", {dX, dY}, 0);
          checkOutput("def_first_flags", {dTick, dVon, dFs, dHs, dVs, dVond}, 6'b011110);
        end
        5:    checkOutput("def_fs_drop_vond", {dFs, dVond}, 2'b01);
        2563: checkOutput("def_x639_von", {dX, dVon}, {10'd639, 1'b1});
        2564: checkOutput("def_x640_von", {dX, dVon}, {10'd640, 1'b0});
        2627: checkOutput("def_x655_hs", {dX, dHs}, {10'd655, 1'b1});
        2628: checkOutput("def_x656_hs", {dX, dHs}, {10'd656, 1'b0});
        3011: checkOutput("def_x751_hs", {dX, dHs}, {10'd751, 1'b0});
        3012: checkOutput("def_x752_hs", {dX, dHs}, {10'd752, 1'b1});
        3200: checkOutput("def_line0_end", {dX, dY}, {10'd799, 10'd0});
        3204: begin
          checkOutput("def_line1_start", {dX, dY, dVon}, {10'd0, 10'd1, 1'b1});
          checkOutput("def_hsync_width", hsLowTicks, 96);
          hsWidthChecked++;
        end
        default: ;
      endcase

      case (kCnt)
        3:   checkOutput("a_first_pixel", {aX, aY, aFs}, {10'd0, 10'd0, 1'b1});
        4:   checkOutput("a_fs_drop", aFs, 0);
        5:   checkOutput("a_vond_pre", aVond, 0);
        6:   checkOutput("a_vond_delay3", aVond, 1);
        317: checkOutput("a_y6_vs", {aX, aY, aVs}, {10'd14, 10'd6, 1'b1});
        318: checkOutput("a_y7_vs", {aX, aY, aVs}, {10'd0, 10'd7, 1'b0});
        405: checkOutput("a_y8_vs", {aX, aY, aVs}, {10'd14, 10'd8, 1'b0});
        408: checkOutput("a_y9_vs", {aX, aY, aVs}, {10'd0, 10'd9, 1'b1});
        450: checkOutput("a_frame_end", {aX, aY, aFs}, {10'd14, 10'd9, 1'b0});
        453: checkOutput("a_frame_wrap", {aX, aY, aFs}, {10'd0, 10'd0, 1'b1});
        default: ;
      endcase

      case (kCnt)
        0:  checkOutput("b_reset_pol", {bX, bY, bHs, bVs, bHsd, bVsd}, {10'd8, 10'd6, 4'b0000});
        11: checkOutput("b_x4_von", {bX, bVon}, {10'd4, 1'b1});
        12: checkOutput("b_x5_von", {bX, bVon}, {10'd5, 1'b0});
        13: checkOutput("b_x5_hs", bHs, 0);
        14: checkOutput("b_x6_hs", {bX, bHs, bHsd}, {10'd6, 2'b11});
        18: checkOutput("b_x8_hs", {bX, bHs}, {10'd8, 1'b0});
        91: checkOutput("b_y4_vs", {bY, bVs}, {10'd4, 1'b0});
        92: checkOutput("b_y5_vs", {bY, bVs, bVsd}, {10'd5, 2'b11});
        default: ;
      endcase

      if (kCnt == 0) begin
        hsLowTicks = 0;
        fsSeen     = 1'b0;
      end
      if (dTick && !dHs && dY == 10'd0) begin
        hsLowTicks++;
      end
      if (aFs) begin
        if (fsSeen) begin
          checkOutput("a_frame_period", kCnt - fsK, 450);
          periodCount++;
        end
        fsSeen = 1'b1;
        fsK    = kCnt;
      end
    end
  end

  initial begin
    cDef = '{div: 4, ha: 640, hfp: 16, hsy: 96, hbp: 48,
             va: 480, vfp: 10, vsy: 2, vbp: 33, pol: 1'b0, dly: 1};
    cA   = '{div: 3, ha: 8, hfp: 2, hsy: 3, hbp: 2,
             va: 6, vfp: 1, vsy: 2, vbp: 1, pol: 1'b0, dly: 3};
    cB   = '{div: 2, ha: 5, hfp: 1, hsy: 2, hbp: 1,
             va: 4, vfp: 1, vsy: 1, vbp: 1, pol: 1'b1, dly: 0};

    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    $display("[TB] reset released, running first line of default raster");
    applyStimulus(3300);

    // Abort the frame while the default raster sits at x=300 mid-pixel.
    pulseReset(1);
    applyStimulus(1204);
    pulseReset(1);
    applyStimulus(600);

    for (int r = 0; r < 6; r++) begin
      applyStimulus($urandom_range(50, 1500));
      pulseReset($urandom_range(1, 3));
    end
    applyStimulus(3300);

    checkOutput("a_frame_period_measured", (periodCount > 0) ? 1 : 0, 1);
    checkOutput("def_hsync_width_measured", (hsWidthChecked > 0) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
